// File: rtl/mul_status.sv
// Multiplier status tracking: ASTAT MV/MN bits, sticky MOS overflow flag,
// saturating overflow event counter and a one-shot overflow interrupt.
module mul_status #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps_mul_en,
    input  logic [1:0]           ps_mul_cls,
    input  logic [1:0]           ps_mul_sc,
    input  logic                 mul_ps_mv,
    input  logic                 mul_ps_mn,
    input  logic                 ps_astat_wr,
    input  logic [1:0]           ps_astat_wdata,
    input  logic                 ps_stky_clr,
    input  logic                 ps_irq_en,
    output logic                 astat_mv,
    output logic                 astat_mn,
    output logic                 stky_mos,
    output logic                 mul_ovf_irq,
    output logic [CNT_WIDTH-1:0] ovf_cnt
);

    localparam logic [1:0]           CLS_MR  = 2'b00;
    localparam logic [1:0]           SC_SAT  = 2'b11;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic                 ex_en_r;
    logic [1:0]           ex_cls_r;
    logic [1:0]           ex_sc_r;
    logic                 astat_mv_r;
    logic                 astat_mn_r;
    logic                 stky_mos_r;
    logic                 stky_dly_r;
    logic                 irq_r;
    logic [CNT_WIDTH-1:0] cnt_r;

    logic                 upd_s;
    logic                 ovf_s;
    logic                 astat_mv_nxt_s;
    logic                 astat_mn_nxt_s;
    logic                 stky_nxt_s;
    logic                 irq_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;

    // Next-state decode for status, sticky bit, counter and interrupt.
    always_comb begin
        upd_s          = 1'b0;
        ovf_s          = 1'b0;
        astat_mv_nxt_s = astat_mv_r;
        astat_mn_nxt_s = astat_mn_r;
        stky_nxt_s     = stky_mos_r;
        cnt_nxt_s      = cnt_r;
        irq_nxt_s      = 1'b0;

        // MR0/MR1/MR2 transfers are the only enabled operations that leave status alone.
        if (ex_en_r && !((ex_cls_r == CLS_MR) && (ex_sc_r != SC_SAT))) begin
            upd_s = 1'b1;
        end else begin
            upd_s = 1'b0;
        end
        ovf_s = upd_s & mul_ps_mv;

        if (upd_s) begin
            astat_mv_nxt_s = mul_ps_mv;
            astat_mn_nxt_s = mul_ps_mn;
        end else if (ps_astat_wr) begin
            astat_mv_nxt_s = ps_astat_wdata[1];
            astat_mn_nxt_s = ps_astat_wdata[0];
        end else begin
            astat_mv_nxt_s = astat_mv_r;
            astat_mn_nxt_s = astat_mn_r;
        end

        // A simultaneous clear loses to a fresh overflow, leaving one counted event.
        if (ovf_s) begin
            stky_nxt_s = 1'b1;
            if (ps_stky_clr) begin
                cnt_nxt_s = CNT_ONE;
            end else begin
                cnt_nxt_s = sat_inc(cnt_r);
            end
        end else if (ps_stky_clr) begin
            stky_nxt_s = 1'b0;
            cnt_nxt_s  = CNT_ZERO;
        end else begin
            stky_nxt_s = stky_mos_r;
            cnt_nxt_s  = cnt_r;
        end

        irq_nxt_s = stky_mos_r & ~stky_dly_r & ps_irq_en;
    end

    // Decode-to-execute pipeline and all status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_en_r    <= 1'b0;
            ex_cls_r   <= 2'b00;
            ex_sc_r    <= 2'b00;
            astat_mv_r <= 1'b0;
            astat_mn_r <= 1'b0;
            stky_mos_r <= 1'b0;
            stky_dly_r <= 1'b0;
            irq_r      <= 1'b0;
            cnt_r      <= CNT_ZERO;
        end else begin
            ex_en_r <= ps_mul_en;
            if (ps_mul_en) begin
                ex_cls_r <= ps_mul_cls;
                ex_sc_r  <= ps_mul_sc;
            end else begin
                ex_cls_r <= ex_cls_r;
                ex_sc_r  <= ex_sc_r;
            end
            astat_mv_r <= astat_mv_nxt_s;
            astat_mn_r <= astat_mn_nxt_s;
            stky_mos_r <= stky_nxt_s;
            stky_dly_r <= stky_mos_r;
            irq_r      <= irq_nxt_s;
            cnt_r      <= cnt_nxt_s;
        end
    end

    assign astat_mv    = astat_mv_r;
    assign astat_mn    = astat_mn_r;
    assign stky_mos    = stky_mos_r;
    assign mul_ovf_irq = irq_r;
    assign ovf_cnt     = cnt_r;

endmodule

// File: tb/tb_mul_status.sv
// Self-checking bench for mul_status: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_mul_status;

    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ps_mul_en = 1'b0;
    logic [1:0]    ps_mul_cls = 2'b00;
    logic [1:0]    ps_mul_sc = 2'b00;
    logic          mul_ps_mv = 1'b0;
    logic          mul_ps_mn = 1'b0;
    logic          ps_astat_wr = 1'b0;
    logic [1:0]    ps_astat_wdata = 2'b00;
    logic          ps_stky_clr = 1'b0;
    logic          ps_irq_en = 1'b1;
    logic          astat_mv;
    logic          astat_mn;
    logic          stky_mos;
    logic          mul_ovf_irq;
    logic [CW-1:0] ovf_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state (transaction view: one pending operation in flight).
    bit m_mv, m_mn, m_stky, m_irq, m_pend, m_irq_due;
    int m_cnt;

    mul_status #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .ps_mul_en(ps_mul_en), .ps_mul_cls(ps_mul_cls), .ps_mul_sc(ps_mul_sc),
        .mul_ps_mv(mul_ps_mv), .mul_ps_mn(mul_ps_mn),
        .ps_astat_wr(ps_astat_wr), .ps_astat_wdata(ps_astat_wdata),
        .ps_stky_clr(ps_stky_clr), .ps_irq_en(ps_irq_en),
        .astat_mv(astat_mv), .astat_mn(astat_mn), .stky_mos(stky_mos),
        .mul_ovf_irq(mul_ovf_irq), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mv = 0; m_mn = 0; m_stky = 0; m_irq = 0; m_pend = 0; m_irq_due = 0; m_cnt = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit upd, ovf, was_sticky;
        upd        = m_pend;
        ovf        = upd && mul_ps_mv;
        was_sticky = m_stky;
        m_irq      = m_irq_due && ps_irq_en;
        if (upd) begin
            m_mv = mul_ps_mv; m_mn = mul_ps_mn;
        end else if (ps_astat_wr) begin
            m_mv = ps_astat_wdata[1]; m_mn = ps_astat_wdata[0];
        end
        if (ovf) begin
            m_stky = 1;
            m_cnt  = ps_stky_clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
        end else if (ps_stky_clr) begin
            m_stky = 0;
            m_cnt  = 0;
        end
        m_irq_due = !was_sticky && m_stky;
        m_pend    = ps_mul_en && !(ps_mul_cls == 2'b00 && ps_mul_sc != 2'b11);
    endtask

    task automatic check_all();
        check("astat_mv", 32'(astat_mv), 32'(m_mv));
        check("astat_mn", 32'(astat_mn), 32'(m_mn));
        check("stky_mos", 32'(stky_mos), 32'(m_stky));
        check("mul_ovf_irq", 32'(mul_ovf_irq), 32'(m_irq));
        check("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        ps_mul_en = 0; ps_mul_cls = 2'b00; ps_mul_sc = 2'b00;
        mul_ps_mv = 0; mul_ps_mn = 0;
        ps_astat_wr = 0; ps_astat_wdata = 2'b00; ps_stky_clr = 0;
    endtask

    task automatic op(input logic [1:0] c, input logic [1:0] s, input logic v, input logic n);
        ps_mul_en = 1; ps_mul_cls = c; ps_mul_sc = s; mul_ps_mv = 0; mul_ps_mn = 0;
        cyc();
        ps_mul_en = 0; mul_ps_mv = v; mul_ps_mn = n;
        cyc();
        mul_ps_mv = 0; mul_ps_mn = 0;
    endtask

    initial begin
        model_reset();
        #1;
        check("reset_mv", 32'(astat_mv), 32'd0);
        check("reset_cnt", 32'(ovf_cnt), 32'd0);
        check_all();

        // Enabled product with overflow held across release: first edge must not update.
        ps_mul_en = 1; ps_mul_cls = 2'b01; mul_ps_mv = 1; mul_ps_mn = 1;
        cyc();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        mul_ps_mv = 1;
        cyc();
        check("first_edge_no_upd", 32'(stky_mos), 32'd0);
        mul_ps_mv = 0;
        cyc();

        // Product with overflow, then interrupt pulse of exactly one cycle.
        op(2'b01, 2'b00, 1'b1, 1'b1);
        check("prod_mv", 32'(astat_mv), 32'd1);
        check("prod_mn", 32'(astat_mn), 32'd1);
        check("prod_stky", 32'(stky_mos), 32'd1);
        check("prod_cnt", 32'(ovf_cnt), 32'd1);
        cyc();
        check("irq_pulse", 32'(mul_ovf_irq), 32'd1);
        cyc();
        check("irq_one_cycle", 32'(mul_ovf_irq), 32'd0);

        // MR1 transfer with overflow forced leaves everything as it was.
        op(2'b00, 2'b01, 1'b1, 1'b0);
        check("mr1_mv", 32'(astat_mv), 32'd1);
        check("mr1_mn", 32'(astat_mn), 32'd1);
        check("mr1_cnt", 32'(ovf_cnt), 32'd1);

        // Second overflow: count advances, no new pulse.
        op(2'b10, 2'b00, 1'b1, 1'b0);
        check("ovf2_cnt", 32'(ovf_cnt), 32'd2);
        cyc();
        check("ovf2_no_irq", 32'(mul_ovf_irq), 32'd0);

        // Clear, then a fresh overflow re-arms the pulse.
        ps_stky_clr = 1;
        cyc();
        ps_stky_clr = 0;
        check("clr_stky", 32'(stky_mos), 32'd0);
        check("clr_cnt", 32'(ovf_cnt), 32'd0);
        op(2'b11, 2'b00, 1'b1, 1'b1);
        check("rearm_cnt", 32'(ovf_cnt), 32'd1);
        cyc();
        check("rearm_irq", 32'(mul_ovf_irq), 32'd1);

        // Software write colliding with an update loses.
        ps_mul_en = 1; ps_mul_cls = 2'b01;
        cyc();
        ps_mul_en = 0; mul_ps_mv = 1; mul_ps_mn = 0; ps_astat_wr = 1; ps_astat_wdata = 2'b00;
        cyc();
        check("wr_vs_upd_mv", 32'(astat_mv), 32'd1);
        mul_ps_mv = 0; ps_astat_wdata = 2'b01;
        cyc();
        ps_astat_wr = 0;
        check("wr_mv", 32'(astat_mv), 32'd0);
        check("wr_mn", 32'(astat_mn), 32'd1);
        check("wr_keeps_cnt", 32'(ovf_cnt), 32'd2);

        // Clear colliding with an overflow update: set wins.
        ps_mul_en = 1; ps_mul_cls = 2'b01;
        cyc();
        ps_mul_en = 0; mul_ps_mv = 1; ps_stky_clr = 1;
        cyc();
        idle_inputs();
        check("clr_vs_ovf_stky", 32'(stky_mos), 32'd1);
        check("clr_vs_ovf_cnt", 32'(ovf_cnt), 32'd1);

        // Random back-to-back traffic against the model.
        for (int i = 0; i < 400; i++) begin
            ps_mul_en      = 1'($urandom_range(0, 3) != 0);
            ps_mul_cls     = 2'($urandom);
            ps_mul_sc      = 2'($urandom);
            mul_ps_mv      = 1'($urandom);
            mul_ps_mn      = 1'($urandom);
            ps_astat_wr    = 1'($urandom_range(0, 7) == 0);
            ps_astat_wdata = 2'($urandom);
            ps_stky_clr    = 1'($urandom_range(0, 15) == 0);
            ps_irq_en      = 1'($urandom_range(0, 3) != 0);
            cyc();
        end
        idle_inputs();
        ps_irq_en = 1;

        // Saturation: 300 consecutive overflowing accumulates.
        ps_stky_clr = 1;
        cyc();
        ps_stky_clr = 0;
        ps_mul_en = 1; ps_mul_cls = 2'b10; ps_mul_sc = 2'b00;
        cyc();
        mul_ps_mv = 1;
        for (int i = 0; i < 300; i++) cyc();
        check("sat_cnt", 32'(ovf_cnt), 32'd255);
        idle_inputs();

        // Reset between decode and execute edges discards the pending update.
        ps_mul_en = 1; ps_mul_cls = 2'b01;
        cyc();
        ps_mul_en = 0; mul_ps_mv = 1; mul_ps_mn = 1;
        #2;
        reset = 0;
        model_reset();
        #1;
        check("midrst_mv", 32'(astat_mv), 32'd0);
        check("midrst_cnt", 32'(ovf_cnt), 32'd0);
        check_all();
        cyc();
        reset = 1;
        cyc();
        cyc();
        check("post_rst_stky", 32'(stky_mos), 32'd0);
        check("post_rst_mv", 32'(astat_mv), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_status.md
MUL_STATUS -- requirements
Module: mul_status

Interface
REQ-001 Parameter CNT_WIDTH, default 8, sets the width of the overflow event counter.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ps_mul_en  input  1  multiplier enable, driven in the decode cycle, same timing as the multiplier's own enable.
REQ-005 ps_mul_cls  input  2  multiplier class, decode cycle: 00 MR/SAT, 01 product, 10 accumulate add, 11 accumulate subtract.
REQ-006 ps_mul_sc  input  2  sub-class, decode cycle: 00/01/10 MR0/MR1/MR2 transfer, 11 SAT MR.
REQ-007 mul_ps_mv  input  1  multiplier overflow flag, valid during the execute cycle.
REQ-008 mul_ps_mn  input  1  multiplier sign flag, valid during the execute cycle.
REQ-009 ps_astat_wr  input  1  software write strobe for the ASTAT multiplier bits.
REQ-010 ps_astat_wdata  input  2  software write data: [1] MV, [0] MN.
REQ-011 ps_stky_clr  input  1  software clear of the sticky MOS bit and of the counter.
REQ-012 ps_irq_en  input  1  overflow interrupt enable (level).
REQ-013 astat_mv  output  1  registered overflow status.
REQ-014 astat_mn  output  1  registered sign status.
REQ-015 stky_mos  output  1  sticky overflow status.
REQ-016 mul_ovf_irq  output  1  one-cycle overflow interrupt pulse.
REQ-017 ovf_cnt  output  CNT_WIDTH  saturating count of overflowing operations.

Function
REQ-018 Decode-cycle inputs ps_mul_en, ps_mul_cls and ps_mul_sc shall be registered at each rising edge into execute-cycle copies ex_en, ex_cls and ex_sc.
- ex_cls and ex_sc load only when ps_mul_en=1.
- ex_en loads every cycle.
REQ-019 upd = ex_en & ~(ex_cls==00 & ex_sc!=11).
- MR0/MR1/MR2 transfers shall never modify any status.
- Product, accumulate and SAT MR operations shall update status.
REQ-020 When upd=1, at the rising edge ending the execute cycle:
- astat_mv <= mul_ps_mv.
- astat_mn <= mul_ps_mn.
- Both become visible two edges after the decode edge.
REQ-021 When upd=1 and mul_ps_mv=1, stky_mos shall be set to 1.
REQ-022 When upd=1 and mul_ps_mv=1, ovf_cnt shall increment by 1 and saturate at all-ones with no wrap.
REQ-023 ps_astat_wr=1 with upd=0 shall load {astat_mv, astat_mn} from ps_astat_wdata.
REQ-024 ps_astat_wr=1 in the same cycle as upd=1 shall be ignored: the hardware update wins.
REQ-025 ps_stky_clr=1 shall clear stky_mos and ovf_cnt to 0 at the next edge.
REQ-026 ps_stky_clr=1 in the same cycle as an overflow update shall make set win:
- stky_mos=1.
- ovf_cnt=1.
REQ-027 ps_astat_wr shall not affect stky_mos or ovf_cnt.
REQ-028 mul_ovf_irq shall be registered and assert for exactly one cycle, on the edge after stky_mos transitions 0->1 while ps_irq_en=1.
- No pulse while stky_mos stays 1.
- A new pulse requires a clear and then a fresh overflow.
REQ-029 Back-to-back updating operations on consecutive cycles shall each update status; no cycle shall be dropped.
REQ-030 The block shall contain no combinational path from any input to any output.

Reset
REQ-031 On reset=0, asynchronously:
- ex_en=0, ex_cls=00, ex_sc=00.
- astat_mv=0, astat_mn=0, stky_mos=0.
- mul_ovf_irq=0, ovf_cnt=0.
REQ-032 Reset asserted mid-operation shall discard any pending execute-cycle update.
REQ-033 The first edge after reset release shall not update status, because ex_en=0.

Verification
REQ-034 Product with overflow:
- Stimulus: cls=01, en=1 at edge 0; mv=1, mn=1 in the next cycle.
- Response: after edge 2, astat_mv=1, astat_mn=1, stky_mos=1, ovf_cnt=1.
REQ-035 MR1 transfer: cls=00, sc=01 with mv=1 forced -> all status unchanged from the prior values.
REQ-036 Interrupt and clear sequence, with ps_irq_en=1:
- Overflow -> mul_ovf_irq high for exactly 1 cycle.
- Second overflow -> no pulse, ovf_cnt=2.
- ps_stky_clr, then overflow -> pulse again, ovf_cnt=1.
REQ-037 Counter saturation: CNT_WIDTH=8 with 300 consecutive overflowing accumulates -> ovf_cnt=255, no wrap.
REQ-038 Simultaneous events:
- ps_astat_wr with data 00 during an update with mv=1 -> astat_mv=1.
- ps_stky_clr during an overflow update -> stky_mos=1, ovf_cnt=1.
REQ-039 Reset mid-operation: reset=0 asserted between the decode edge and the execute edge -> all outputs 0 immediately, and they stay 0 after release.
